// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
// Patterns are passed zero-extended to N_MAX bits; the first bit in time is bit len-1.
package seq_det_pkg;

  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 16;
  localparam int unsigned IDX_W = $clog2(N_MAX);

  typedef logic [IDX_W-1:0] idx_t;

  // Longest proper prefix of the pattern that is also a suffix of it.
  function automatic idx_t border_len(input logic [N_MAX-1:0] pattern, input int unsigned len);
    idx_t best;
    logic ok;
    best = '0;
    for (int unsigned b = 1; b < len; b++) begin
      ok = 1'b1;
      for (int unsigned t = 0; t < b; t++) begin
        if (pattern[idx_t'(len - 1 - t)] != pattern[idx_t'(b - 1 - t)]) ok = 1'b0;
      end
      if (ok) best = idx_t'(b);
    end
    return best;
  endfunction

  function automatic idx_t onehot_to_idx(input logic [N_MAX-1:0] oh);
    idx_t idx;
    idx = '0;
    for (int i = 0; i < N_MAX; i++) begin
      if (oh[i]) idx = idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational next-state and hit logic for the one-hot pattern matcher.
// The fallback state for every Sk is derived from the pattern itself, with no bit history.
module seq_det_next_state
  import seq_det_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] state,
  input  logic         din,
  input  logic [N-1:0] pattern,
  input  logic         overlap,
  output logic [N-1:0] next_state,
  output logic         hit
);

  localparam int unsigned PW = $clog2(N);

  logic [N-1:0]               p;
  logic [N_MAX-1:0][IDX_W-1:0] fall_pad;
  idx_t                       idx;
  idx_t                       border;

  // p[i] is the i-th pattern bit in arrival order.
  for (genvar i = 0; i < N; i++) begin : g_order
    assign p[i] = pattern[N-1-i];
  end

  // For Sk, the candidate string is p[0..k-1] followed by din; keep the longest
  // suffix of it that is also a pattern prefix.
  for (genvar k = 0; k < N; k++) begin : g_fail
    idx_t fall;
    logic ok;
    always_comb begin
      fall = '0;
      ok   = 1'b0;
      for (int j = 1; j <= k + 1 && j < N; j++) begin
        ok = (din == p[PW'(j - 1)]);
        for (int t = 0; t < j - 1; t++) begin
          if (p[PW'(k + 1 - j + t)] != p[PW'(t)]) ok = 1'b0;
        end
        if (ok) fall = idx_t'(j);
      end
    end
    assign fall_pad[k] = fall;
  end

  for (genvar k = N; k < N_MAX; k++) begin : g_pad
    assign fall_pad[k] = '0;
  end

  assign idx    = onehot_to_idx(N_MAX'(state));
  assign border = border_len(N_MAX'(pattern), N);

  always_comb begin
    hit        = 1'b0;
    next_state = N'(1);
    if ($onehot(state)) begin
      if (state[N-1] && (din == p[N-1])) begin
        hit = 1'b1;
        if (overlap) next_state = N'(1) << border;
      end else begin
        next_state = N'(1) << fall_pad[idx];
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a run-time loadable N-bit pattern, overlap control,
// a Mealy hit, its registered copy and a saturating hit counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             load,
  input  logic [N-1:0]     pattern_in,
  input  logic             overlap,
  input  logic             clear_count,
  output logic             dout,
  output logic             hit_reg,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam logic [N-1:0] S0 = N'(1);

  logic [N-1:0] state_q;
  logic [N-1:0] pattern_q;
  logic [N-1:0] state_nxt;
  logic         hit;

  seq_det_next_state #(
    .N(N)
  ) u_next_state (
    .state     (state_q),
    .din       (din),
    .pattern   (pattern_q),
    .overlap   (overlap),
    .next_state(state_nxt),
    .hit       (hit)
  );

  assign dout      = din_valid && !load && hit;
  assign count_sat = &match_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S0;
      pattern_q   <= '0;
      hit_reg     <= 1'b0;
      match_count <= '0;
    end else begin
      hit_reg <= dout;
      if (load) begin
        pattern_q <= pattern_in;
        state_q   <= S0;
      end else if (din_valid) begin
        state_q <= state_nxt;
      end
      // A hit in the clear cycle still counts.
      if (clear_count) begin
        match_count <= CNT_W'(dout);
      end else if (dout && !count_sat) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed literal sequences plus randomized traffic
// checked every cycle against a history-based model of the matcher.
module tb_seq_detector_param;

  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int CW2  = 2;
  localparam int MAX1 = (1 << CW) - 1;
  localparam int MAX2 = (1 << CW2) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic load = 1'b0;
  logic overlap = 1'b0;
  logic clear_count = 1'b0;
  logic [N-1:0] pattern_in = '0;

  logic dout, hit_reg, count_sat;
  logic [CW-1:0] match_count;
  logic dout2, hit_reg2, count_sat2;
  logic [CW2-1:0] match_count2;

  int errors = 0;
  int checks = 0;
  logic prev_exp = 1'b0;

  always #5 clk = ~clk;

  seq_detector_param #(.N(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .load(load),
    .pattern_in(pattern_in), .overlap(overlap), .clear_count(clear_count),
    .dout(dout), .hit_reg(hit_reg), .match_count(match_count), .count_sat(count_sat)
  );

  seq_detector_param #(.N(N), .CNT_W(CW2)) dut2 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .load(load),
    .pattern_in(pattern_in), .overlap(overlap), .clear_count(clear_count),
    .dout(dout2), .hit_reg(hit_reg2), .match_count(match_count2), .count_sat(count_sat2)
  );

  // Model: the accepted bits since the last load / non-overlapping hit; a hit is
  // simply "the last N bits of that history equal the pattern".
  logic [N-1:0] m_pat  = '0;
  logic [N-1:0] m_hist = '0;
  int           m_len  = 0;
  logic         m_hr   = 1'b0;
  int           m_cnt  = 0;
  int           m_cnt2 = 0;

  function automatic logic m_dout();
    if (!din_valid || load || m_len < N - 1) return 1'b0;
    return {m_hist[N-2:0], din} == m_pat;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pat  <= '0;
      m_hist <= '0;
      m_len  <= 0;
      m_hr   <= 1'b0;
      m_cnt  <= 0;
      m_cnt2 <= 0;
    end else begin
      m_hr <= m_dout();
      if (clear_count) m_cnt <= int'(m_dout());
      else if (m_dout() && m_cnt < MAX1) m_cnt <= m_cnt + 1;
      if (clear_count) m_cnt2 <= int'(m_dout());
      else if (m_dout() && m_cnt2 < MAX2) m_cnt2 <= m_cnt2 + 1;
      if (load) begin
        m_pat  <= pattern_in;
        m_hist <= '0;
        m_len  <= 0;
      end else if (din_valid) begin
        if (m_dout() && !overlap) begin
          m_hist <= '0;
          m_len  <= 0;
        end else begin
          m_hist <= {m_hist[N-2:0], din};
          m_len  <= (m_len < N) ? m_len + 1 : N;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("dout", int'(dout), int'(m_dout()));
    chk("hit_reg", int'(hit_reg), int'(m_hr));
    chk("match_count", int'(match_count), m_cnt);
    chk("count_sat", int'(count_sat), int'(m_cnt == MAX1));
    chk("dout2", int'(dout2), int'(m_dout()));
    chk("match_count2", int'(match_count2), m_cnt2);
    chk("count_sat2", int'(count_sat2), int'(m_cnt2 == MAX2));
  end

  task automatic drive(input logic d, input logic v, input logic ld, input logic [N-1:0] pat,
                       input logic clr);
    din = d; din_valid = v; load = ld; pattern_in = pat; clear_count = clr;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pat(input logic [N-1:0] pat, input logic ov, input logic clr);
    overlap = ov;
    drive(1'b1, 1'b1, 1'b1, pat, clr);
    chk("lit_load_dout", int'(dout), 0);
    adv();
    prev_exp = 1'b0;
  endtask

  task automatic send(input logic d, input logic exp_d);
    drive(d, 1'b1, 1'b0, '0, 1'b0);
    chk("lit_dout", int'(dout), int'(exp_d));
    chk("lit_hit_reg", int'(hit_reg), int'(prev_exp));
    adv();
    prev_exp = exp_d;
  endtask

  task automatic stream7(input logic [6:0] bits, input logic [6:0] exp);
    for (int i = 6; i >= 0; i--) send(bits[i], exp[i]);
  endtask

  task automatic idle_count(input int exp_cnt);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("lit_count", int'(match_count), exp_cnt);
    chk("lit_hit_reg_idle", int'(hit_reg), int'(prev_exp));
    adv();
    prev_exp = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_dout", int'(dout), 0);
    chk("reset_hit_reg", int'(hit_reg), 0);
    chk("reset_count", int'(match_count), 0);
    chk("reset_sat", int'(count_sat), 0);
    rst_n = 1'b1;
    adv();

    load_pat(4'b1011, 1'b1, 1'b1);
    stream7(7'b1011011, 7'b0001001);
    idle_count(2);
    load_pat(4'b1011, 1'b0, 1'b1);
    stream7(7'b1011011, 7'b0001000);
    idle_count(1);
    load_pat(4'b1111, 1'b1, 1'b1);
    stream7(7'b1111111, 7'b0001111);
    idle_count(4);
    load_pat(4'b1111, 1'b0, 1'b1);
    stream7(7'b1111111, 7'b0001000);
    idle_count(1);

    // Gaps in S3 must hold the state.
    load_pat(4'b1011, 1'b1, 1'b1);
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      chk("lit_gap_dout", int'(dout), 0);
      adv();
    end
    prev_exp = 1'b0;
    send(1'b1, 1'b1);
    idle_count(1);

    // Load while in S3 with a matching bit: no hit, new pattern takes over.
    load_pat(4'b1011, 1'b1, 1'b1);
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    chk("lit_load_in_s3", int'(dout), 0);
    adv();
    prev_exp = 1'b0;
    send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b1);
    idle_count(1);

    // Saturation of the 2-bit counter.
    load_pat(4'b1111, 1'b1, 1'b1);
    send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
      chk("lit_sat_dout", int'(dout), 1);
      chk("lit_count2", int'(match_count2), (i < 3) ? i : 3);
      chk("lit_sat2", int'(count_sat2), int'(i >= 3));
      adv();
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("lit_count2_final", int'(match_count2), 3);
    chk("lit_sat2_final", int'(count_sat2), 1);
    chk("lit_count_final", int'(match_count), 5);
    adv();

    // Clear in a hit cycle keeps that hit.
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
    chk("lit_clear_hit_dout", int'(dout), 1);
    adv();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("lit_clear_count", int'(match_count), 1);
    chk("lit_clear_count2", int'(match_count2), 1);
    chk("lit_clear_sat2", int'(count_sat2), 0);
    adv();

    // Asynchronous reset mid-cycle, right after a hit.
    load_pat(4'b1011, 1'b1, 1'b0);
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b1);
    din = 1'b1; din_valid = 1'b1; load = 1'b0; clear_count = 1'b0;
    #1;
    chk("lit_pre_rst_hit_reg", int'(hit_reg), 1);
    chk("lit_pre_rst_count", int'(match_count), 2);
    rst_n = 1'b0;
    #1;
    chk("lit_rst_dout", int'(dout), 0);
    chk("lit_rst_hit_reg", int'(hit_reg), 0);
    chk("lit_rst_count", int'(match_count), 0);
    chk("lit_rst_sat2", int'(count_sat2), 0);
    rst_n = 1'b1;
    adv();
    prev_exp = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      din         = 1'($urandom_range(0, 1));
      din_valid   = ($urandom_range(0, 9) < 8);
      load        = ($urandom_range(0, 63) == 0);
      pattern_in  = N'($urandom);
      clear_count = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 15) == 0) overlap = ~overlap;
      if (c % 1000 == 999) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
